// File: rtl/judge_pkg.sv
// Shared lane indices and encodings for the arrow judge.
package judge_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_LEFT  = 0;
    localparam int LANE_RIGHT = 1;
    localparam int LANE_UP    = 2;
    localparam int LANE_DOWN  = 3;

    typedef enum logic {
        LANE_IDLE  = 1'b0,
        LANE_ARMED = 1'b1
    } lane_state_e;

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'd0,
        GRADE_PERFECT = 2'd1,
        GRADE_GOOD    = 2'd2,
        GRADE_MISS    = 2'd3
    } grade_e;

endpackage

// File: rtl/judge_lane.sv
// One judging lane: button synchroniser, rising-edge detect, target FSM, age counter.
//   state      | meaning
//   LANE_IDLE  | no live target; a press here is a stray
//   LANE_ARMED | target live, age counts ms since its pulse
module judge_lane
    import judge_pkg::*;
#(
    parameter int WINDOW_MS  = 200,
    parameter int PERFECT_MS = 50,
    parameter int AGE_W      = 8
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   tick_ms_i,
    input  logic   tgt_i,
    input  logic   done_i,
    input  logic   btn_i,
    output logic   armed_o,
    output grade_e grade_o,
    output logic   stray_o
);

    localparam logic [AGE_W-1:0] AGE_LAST    = AGE_W'(WINDOW_MS - 1);
    localparam logic [AGE_W-1:0] AGE_PERFECT = AGE_W'(PERFECT_MS);

    logic             sync1_q, sync2_q, prev_q;
    lane_state_e      state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    grade_e           grade_q, grade_d;
    logic             stray_q, stray_d;
    logic             press, expire, retire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= LANE_IDLE;
            age_q   <= '0;
            grade_q <= GRADE_NONE;
            stray_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            age_q   <= age_d;
            grade_q <= grade_d;
            stray_q <= stray_d;
        end
    end

    assign press  = sync2_q & ~prev_q;
    assign expire = tick_ms_i && (age_q == AGE_LAST);
    assign retire = press || expire || tgt_i;

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        grade_d = GRADE_NONE;
        stray_d = 1'b0;
        if (done_i) begin
            state_d = LANE_IDLE;
            age_d   = '0;
        end else begin
            case (state_q)
                LANE_IDLE: begin
                    stray_d = press;
                    if (tgt_i) begin
                        state_d = LANE_ARMED;
                        age_d   = '0;
                    end
                end
                LANE_ARMED: begin
                    if (press) begin
                        grade_d = (age_q < AGE_PERFECT) ? GRADE_PERFECT : GRADE_GOOD;
                    end else if (expire || tgt_i) begin
                        grade_d = GRADE_MISS;
                    end else if (tick_ms_i) begin
                        age_d = age_q + AGE_W'(1);
                    end
                    // A same-cycle target re-arms after the old one is graded.
                    if (retire) begin
                        state_d = tgt_i ? LANE_ARMED : LANE_IDLE;
                        age_d   = '0;
                    end
                end
                default: state_d = LANE_IDLE;
            endcase
        end
    end

    assign armed_o = (state_q == LANE_ARMED);
    assign grade_o = grade_q;
    assign stray_o = stray_q;

endmodule

// File: rtl/arrow_judge.sv
// Arrow judge top: four lanes, grade summation, saturating score and combo.
// Optional JUDGE_COMBO_BONUS_EN adds (combo>>3) extra points per hit.
module arrow_judge
    import judge_pkg::*;
#(
    parameter int WINDOW_MS   = 200,
    parameter int PERFECT_MS  = 50,
    parameter int AGE_W       = 8,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_ms_i,
    input  logic [3:0]         tgt_i,
    input  logic               done_i,
    input  logic [3:0]         btn_i,
    output logic [3:0]         lane_armed_o,
    output logic [3:0]         hit_perfect_o,
    output logic [3:0]         hit_good_o,
    output logic [3:0]         miss_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [COMBO_W-1:0] combo_o
);

    localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
    localparam logic [31:0] COMBO_MAX = (32'd1 << COMBO_W) - 32'd1;

    grade_e               grade [NUM_LANES];
    logic [3:0]           stray;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [2:0]           n_perf, n_good, n_hit;
    logic                 any_break;
    logic [31:0]          add_pts, score_sum, combo_sum;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        judge_lane #(
            .WINDOW_MS (WINDOW_MS),
            .PERFECT_MS(PERFECT_MS),
            .AGE_W     (AGE_W)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .tick_ms_i(tick_ms_i),
            .tgt_i    (tgt_i[i]),
            .done_i   (done_i),
            .btn_i    (btn_i[i]),
            .armed_o  (lane_armed_o[i]),
            .grade_o  (grade[i]),
            .stray_o  (stray[i])
        );
        assign hit_perfect_o[i] = (grade[i] == GRADE_PERFECT);
        assign hit_good_o[i]    = (grade[i] == GRADE_GOOD);
        assign miss_o[i]        = (grade[i] == GRADE_MISS);
    end

    always_comb begin
        n_perf = '0;
        n_good = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_perf = n_perf + {2'b00, hit_perfect_o[i]};
            n_good = n_good + {2'b00, hit_good_o[i]};
        end
        n_hit     = n_perf + n_good;
        any_break = (|miss_o) || (|stray);
    end

    always_comb begin
        add_pts = 32'(PERFECT_PTS) * 32'(n_perf) + 32'(GOOD_PTS) * 32'(n_good);
`ifdef JUDGE_COMBO_BONUS_EN
        // Bonus uses the combo as it stood before this update.
        add_pts = add_pts + 32'(n_hit) * 32'(combo_q >> 3);
`endif
        score_sum = 32'(score_q) + add_pts;
        combo_sum = 32'(combo_q) + 32'(n_hit);
        score_d   = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
        if (any_break) begin
            combo_d = '0;
        end else begin
            combo_d = (combo_sum > COMBO_MAX) ? '1 : combo_sum[COMBO_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q <= '0;
            combo_q <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign score_o = score_q;
    assign combo_o = combo_q;

endmodule
